// File: rtl/uart_boot_ctrl.sv
// UART boot loader: waits for a SYNC-framed image on the UART, writes it into
// program RAM, answers ACK/NAK, then releases the CPU. If no SYNC arrives
// within BOOT_WAIT_CYC cycles the existing RAM contents are booted directly.
// Ports:
//   clock, reset              system clock, async active-high reset
//   rx_byte, rx_valid         received UART byte + one-cycle strobe
//   tx_busy, tx_start, tx_byte  UART transmitter handshake
//   cpu_reset                 high while the loader owns the RAM
//   cpu_addr/dout/mem_rd/mem_wr  CPU memory port (used only in RUN)
//   mem_addr/din/rd/wr        program RAM port
module uart_boot_ctrl #(
    parameter int unsigned ADDR_W        = 8,
    parameter int unsigned BOOT_WAIT_CYC = 1200000,
    parameter int unsigned BYTE_TO_CYC   = 120000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        rx_byte,
    input  logic              rx_valid,
    input  logic              tx_busy,
    output logic              tx_start,
    output logic [7:0]        tx_byte,
    output logic              cpu_reset,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_dout,
    input  logic              cpu_mem_rd,
    input  logic              cpu_mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    output logic              mem_rd,
    output logic              mem_wr
);

    localparam int unsigned BOOT_W = $clog2(BOOT_WAIT_CYC + 1);
    localparam int unsigned TO_W   = $clog2(BYTE_TO_CYC + 1);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [7:0]  SYNC   = 8'hA5;
    localparam logic [7:0]  ACK    = 8'h06;
    localparam logic [7:0]  NAK    = 8'h15;

    typedef enum logic [2:0] {
        S_WAIT_SYNC, S_LEN_H, S_LEN_L, S_DATA, S_CSUM, S_RESP, S_RUN
    } state_t;

    state_t              state_q, state_d;
    logic [BOOT_W-1:0]   boot_cnt_q, boot_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [7:0]          csum_q, csum_d;
    logic [7:0]          resp_q, resp_d;
    logic                tx_start_q, tx_start_d;
    logic [7:0]          tx_byte_q, tx_byte_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                ld_wr_q, ld_wr_d;
    logic [ADDR_W-1:0]   ld_addr_q, ld_addr_d;
    logic [7:0]          ld_din_q, ld_din_d;

    logic        is_sync, boot_exp, to_exp, last_byte, len_bad, in_frame, run;
    logic [15:0] len_new;

    assign is_sync   = rx_valid && (rx_byte == SYNC);
    assign boot_exp  = (boot_cnt_q == BOOT_W'(BOOT_WAIT_CYC - 1));
    assign to_exp    = (to_cnt_q == TO_W'(BYTE_TO_CYC - 1));
    assign last_byte = (cnt_q == (len_q - 16'd1));
    assign len_new   = {len_q[15:8], rx_byte};
    assign len_bad   = (len_new == 16'd0) || (32'(len_new) > DEPTH);
    assign in_frame  = (state_q == S_LEN_H) || (state_q == S_LEN_L) ||
                       (state_q == S_DATA)  || (state_q == S_CSUM);
    assign run       = (state_q == S_RUN);

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_WAIT_SYNC;
            boot_cnt_q  <= '0;
            to_cnt_q    <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            csum_q      <= '0;
            resp_q      <= '0;
            tx_start_q  <= 1'b0;
            tx_byte_q   <= '0;
            cpu_reset_q <= 1'b1;
            ld_wr_q     <= 1'b0;
            ld_addr_q   <= '0;
            ld_din_q    <= '0;
        end else begin
            state_q     <= state_d;
            boot_cnt_q  <= boot_cnt_d;
            to_cnt_q    <= to_cnt_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            csum_q      <= csum_d;
            resp_q      <= resp_d;
            tx_start_q  <= tx_start_d;
            tx_byte_q   <= tx_byte_d;
            cpu_reset_q <= cpu_reset_d;
            ld_wr_q     <= ld_wr_d;
            ld_addr_q   <= ld_addr_d;
            ld_din_q    <= ld_din_d;
        end
    end

    // Next-state logic; a received byte always beats a same-cycle timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_WAIT_SYNC: if (is_sync) state_d = S_LEN_H;
                         else if (boot_exp) state_d = S_RUN;
            S_LEN_H:     if (rx_valid) state_d = S_LEN_L;
                         else if (to_exp) state_d = S_WAIT_SYNC;
            S_LEN_L:     if (rx_valid) state_d = len_bad ? S_RESP : S_DATA;
                         else if (to_exp) state_d = S_WAIT_SYNC;
            S_DATA:      if (rx_valid) begin
                             if (last_byte) state_d = S_CSUM;
                         end else if (to_exp) state_d = S_WAIT_SYNC;
            S_CSUM:      if (rx_valid) state_d = S_RESP;
                         else if (to_exp) state_d = S_WAIT_SYNC;
            S_RESP:      if (!tx_busy) state_d = (resp_q == ACK) ? S_RUN : S_WAIT_SYNC;
            S_RUN:       state_d = S_RUN;
            default:     state_d = S_WAIT_SYNC;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        boot_cnt_d  = '0;
        to_cnt_d    = '0;
        len_d       = len_q;
        cnt_d       = cnt_q;
        csum_d      = csum_q;
        resp_d      = resp_q;
        tx_start_d  = 1'b0;
        tx_byte_d   = tx_byte_q;
        cpu_reset_d = !run;
        ld_wr_d     = 1'b0;
        ld_addr_d   = ld_addr_q;
        ld_din_d    = ld_din_q;

        // Boot-wait counter runs only while remaining in WAIT_SYNC, so it
        // restarts from zero on every entry.
        if (state_q == S_WAIT_SYNC && state_d == S_WAIT_SYNC)
            boot_cnt_d = boot_cnt_q + BOOT_W'(1);

        if (in_frame && !rx_valid)
            to_cnt_d = to_cnt_q + TO_W'(1);

        unique case (state_q)
            S_WAIT_SYNC: if (is_sync) begin
                len_d  = '0;
                cnt_d  = '0;
                csum_d = '0;
            end
            S_LEN_H: if (rx_valid) len_d = {rx_byte, 8'h00};
            S_LEN_L: if (rx_valid) begin
                len_d = len_new;
                if (len_bad) resp_d = NAK;
            end
            S_DATA: if (rx_valid) begin
                ld_wr_d   = 1'b1;
                ld_addr_d = ADDR_W'(cnt_q);
                ld_din_d  = rx_byte;
                cnt_d     = cnt_q + 16'd1;
                csum_d    = csum_q + rx_byte;
            end
            S_CSUM: if (rx_valid) resp_d = (rx_byte == csum_q) ? ACK : NAK;
            S_RESP: if (!tx_busy) begin
                tx_start_d = 1'b1;
                tx_byte_d  = resp_q;
            end
            default: ;
        endcase
    end

    // RAM port: CPU pass-through in RUN, loader-owned otherwise
    assign mem_addr  = run ? cpu_addr   : ld_addr_q;
    assign mem_din   = run ? cpu_dout   : ld_din_q;
    assign mem_rd    = run ? cpu_mem_rd : 1'b0;
    assign mem_wr    = run ? cpu_mem_wr : ld_wr_q;
    assign tx_start  = tx_start_q;
    assign tx_byte   = tx_byte_q;
    assign cpu_reset = cpu_reset_q;

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Self-checking bench for uart_boot_ctrl: table of frames plus hand-written
// corner sequences; RAM writes and tx bytes are checked through a scoreboard.
module tb_uart_boot_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_byte = '0;
    logic       rx_valid = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       cpu_reset;
    logic [7:0] cpu_addr = '0;
    logic [7:0] cpu_dout = '0;
    logic       cpu_mem_rd = 1'b0;
    logic       cpu_mem_wr = 1'b0;
    logic [7:0] mem_addr;
    logic [7:0] mem_din;
    logic       mem_rd;
    logic       mem_wr;

    uart_boot_ctrl #(.ADDR_W(8), .BOOT_WAIT_CYC(1000), .BYTE_TO_CYC(200)) dut (
        .clock(clock), .reset(reset), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_busy(tx_busy), .tx_start(tx_start), .tx_byte(tx_byte),
        .cpu_reset(cpu_reset), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .cpu_mem_rd(cpu_mem_rd), .cpu_mem_wr(cpu_mem_wr), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    always #5 clock = ~clock;

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    typedef struct {
        logic [63:0] bytes;   // frame bytes, left-aligned, first byte in [63:56]
        int          n;
        int          hdr;     // index of the SYNC byte
        logic [7:0]  resp;
        bit          run;
    } vec_t;

    wr_t        exp_wr[$];
    logic [7:0] exp_tx[$];
    wr_t        mon_w;
    logic [7:0] mon_t;
    int errors = 0;
    int checks = 0;
    int tx_pulses = 0;
    int wr_pulses = 0;
    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] getb(input logic [63:0] bs, input int i);
        return bs[63-8*i -: 8];
    endfunction

    // Scoreboard monitor: loader writes and every tx_start pop expectations
    always @(negedge clock) begin
        if (!reset) begin
            if (mem_wr && cpu_reset) begin
                wr_pulses++;
                checks++;
                if (exp_wr.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_wr: got addr=%0h din=%0h expected none", mem_addr, mem_din);
                end else begin
                    mon_w = exp_wr.pop_front();
                    if (mem_addr !== mon_w.a || mem_din !== mon_w.d) begin
                        errors++;
                        $display("FAIL wr: got addr=%0h din=%0h expected addr=%0h din=%0h",
                                 mem_addr, mem_din, mon_w.a, mon_w.d);
                    end
                end
            end
            if (tx_start) begin
                tx_pulses++;
                checks++;
                if (exp_tx.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tx: got %0h expected none", tx_byte);
                end else begin
                    mon_t = exp_tx.pop_front();
                    if (tx_byte !== mon_t) begin
                        errors++;
                        $display("FAIL tx_byte: got %0h expected %0h", tx_byte, mon_t);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        rx_valid = 1'b0;
        tx_busy = 1'b0;
        cpu_mem_wr = 1'b0;
        cpu_mem_rd = 1'b0;
        repeat (2) @(posedge clock);
        exp_wr.delete();
        exp_tx.delete();
        tx_pulses = 0;
        wr_pulses = 0;
        #1 reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clock);
        #1 rx_byte = b; rx_valid = 1'b1;
        @(posedge clock);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 300 && (exp_tx.size() != 0 || exp_wr.size() != 0); i++)
            @(posedge clock);
        #2;
        chk(nm, 32'(exp_tx.size() + exp_wr.size()), 32'd0);
    endtask

    // Push expected writes and response for a simple frame, then send it
    task automatic frame(input logic [7:0] d, input logic [7:0] cs, input logic [7:0] resp);
        exp_wr.push_back('{a: 8'h00, d: d});
        exp_tx.push_back(resp);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(d); send_byte(cs);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [15:0] len;
        do_reset();
        len = {getb(v.bytes, v.hdr + 1), getb(v.bytes, v.hdr + 2)};
        if (len != 16'd0 && len <= 16'd256)
            for (int i = 0; i < int'(len); i++)
                exp_wr.push_back('{a: 8'(i), d: getb(v.bytes, v.hdr + 3 + i)});
        exp_tx.push_back(v.resp);
        for (int i = 0; i < v.n; i++) send_byte(getb(v.bytes, i));
        wait_drain($sformatf("vec%0d_drain", idx));
        repeat (3) @(posedge clock);
        #1;
        chk($sformatf("vec%0d_cpu_reset", idx), 32'(cpu_reset), 32'(!v.run));
        chk($sformatf("vec%0d_tx_pulses", idx), 32'(tx_pulses), 32'd1);
        chk($sformatf("vec%0d_tx_hold", idx), 32'(tx_byte), 32'(v.resp));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'hA500031122336600, 7, 0, 8'h06, 1'b1};  // valid load
        vecs[1] = '{64'hA500014243000000, 5, 0, 8'h15, 1'b0};  // bad checksum
        vecs[2] = '{64'hA501010000000000, 3, 0, 8'h15, 1'b0};  // LEN 257
        vecs[3] = '{64'hA500000000000000, 3, 0, 8'h15, 1'b0};  // LEN 0
        vecs[4] = '{64'h00A50002AA55FF00, 7, 1, 8'h06, 1'b1};  // junk before SYNC
        vecs[5] = '{64'hA50002F020100000, 6, 0, 8'h06, 1'b1};  // checksum wraps

        // Reset values
        #12;
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_din", 32'(mem_din), 32'd0);

        foreach (vecs[i]) run_vec(vecs[i], i);

        // NAK then a valid frame in the same session
        do_reset();
        frame(8'h42, 8'h43, 8'h15);
        wait_drain("nak_then_ack_nak");
        chk("nak_cpu_reset", 32'(cpu_reset), 32'd1);
        frame(8'h42, 8'h42, 8'h06);
        wait_drain("nak_then_ack_ack");
        repeat (3) @(posedge clock); #1;
        chk("nak_then_ack_run", 32'(cpu_reset), 32'd0);

        // RUN pass-through and ignored rx
        cpu_addr = 8'h10; cpu_dout = 8'h5A; cpu_mem_wr = 1'b1; #1;
        chk("pt_mem_wr", 32'(mem_wr), 32'd1);
        chk("pt_mem_addr", 32'(mem_addr), 32'h10);
        chk("pt_mem_din", 32'(mem_din), 32'h5A);
        chk("pt_mem_rd0", 32'(mem_rd), 32'd0);
        cpu_mem_wr = 1'b0; cpu_mem_rd = 1'b1; #1;
        chk("pt_mem_rd1", 32'(mem_rd), 32'd1);
        chk("pt_mem_wr0", 32'(mem_wr), 32'd0);
        cpu_mem_rd = 1'b0;
        send_byte(8'hA5);
        repeat (20) @(posedge clock); #1;
        chk("run_rx_ignored_tx", 32'(tx_pulses), 32'd2);
        chk("run_rx_ignored_rst", 32'(cpu_reset), 32'd0);

        // CPU strobes blocked outside RUN
        do_reset();
        cpu_addr = 8'h33; cpu_mem_wr = 1'b1; cpu_mem_rd = 1'b1;
        repeat (3) @(posedge clock); #1;
        chk("block_mem_wr", 32'(mem_wr), 32'd0);
        chk("block_mem_rd", 32'(mem_rd), 32'd0);
        cpu_mem_wr = 1'b0; cpu_mem_rd = 1'b0;

        // Boot timeout
        do_reset();
        repeat (990) @(posedge clock); #1;
        chk("boot_not_yet", 32'(cpu_reset), 32'd1);
        repeat (20) @(posedge clock); #1;
        chk("boot_cpu_reset", 32'(cpu_reset), 32'd0);
        chk("boot_tx_pulses", 32'(tx_pulses), 32'd0);
        chk("boot_wr_pulses", 32'(wr_pulses), 32'd0);

        // SYNC arriving in the boot-expiry cycle wins
        do_reset();
        repeat (998) @(posedge clock);
        exp_wr.push_back('{a: 8'h00, d: 8'h5A});
        exp_tx.push_back(8'h06);
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h5A); send_byte(8'h5A);
        wait_drain("sync_vs_boot");

        // Inter-byte timeout, then a good frame
        do_reset();
        exp_wr.push_back('{a: 8'h00, d: 8'h11});
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02); send_byte(8'h11);
        repeat (210) @(posedge clock); #1;
        chk("to_tx_pulses", 32'(tx_pulses), 32'd0);
        chk("to_cpu_reset", 32'(cpu_reset), 32'd1);
        frame(8'h07, 8'h07, 8'h06);
        wait_drain("to_then_ack");

        // tx_busy holds the response
        do_reset();
        tx_busy = 1'b1;
        frame(8'h11, 8'h11, 8'h06);
        repeat (20) @(posedge clock); #1;
        chk("busy_no_tx", 32'(tx_pulses), 32'd0);
        chk("busy_cpu_reset", 32'(cpu_reset), 32'd1);
        tx_busy = 1'b0;
        wait_drain("busy_release");
        repeat (5) @(posedge clock); #1;
        chk("busy_tx_hold", 32'(tx_byte), 32'h06);

        // Reset mid-frame aborts silently
        do_reset();
        exp_wr.push_back('{a: 8'h00, d: 8'h11});
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h03); send_byte(8'h11);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1; #1;
        chk("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("midrst_tx_byte", 32'(tx_byte), 32'd0);
        chk("midrst_mem_wr", 32'(mem_wr), 32'd0);
        chk("midrst_wr_seen", 32'(wr_pulses), 32'd1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        repeat (20) @(posedge clock); #1;
        chk("midrst_no_tx", 32'(tx_pulses), 32'd0);
        frame(8'h33, 8'h33, 8'h06);
        wait_drain("midrst_then_ack");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_boot_ctrl.md
UART_BOOT_CTRL -- requirements
Module: uart_boot_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program-RAM address width; RAM depth is 2^ADDR_W bytes.
REQ-002 SHALL have parameter BOOT_WAIT_CYC, default 1200000, cycles without SYNC before booting existing RAM contents.
REQ-003 SHALL have parameter BYTE_TO_CYC, default 120000, inter-byte timeout inside a frame.
REQ-004 Ports SHALL be exactly the following. Reset is asynchronous and active-high; the clock is clock.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- rx_byte  in  8  UART received byte.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle transmit strobe.
- tx_byte  out  8  byte to transmit.
- cpu_reset  out  1  CPU reset, high while the loader owns RAM.
- cpu_addr  in  ADDR_W  CPU memory address.
- cpu_dout  in  8  CPU write data.
- cpu_mem_rd  in  1  CPU memory read.
- cpu_mem_wr  in  1  CPU memory write.
- mem_addr  out  ADDR_W  RAM address.
- mem_din  out  8  RAM write data.
- mem_rd  out  1  RAM read enable.
- mem_wr  out  1  RAM write enable.

Function
REQ-005 SHALL implement the states WAIT_SYNC, LEN_H, LEN_L, DATA, CSUM, RESP and RUN.
REQ-006 WAIT_SYNC: rx_valid with rx_byte == 0xA5 -> LEN_H; clear the checksum accumulator, the address counter and the timeout counter.
REQ-007 WAIT_SYNC: any other received byte SHALL be ignored.
REQ-008 WAIT_SYNC: the boot-wait counter increments each cycle and restarts on every entry to WAIT_SYNC.
REQ-009 WAIT_SYNC: boot-wait counter reaching BOOT_WAIT_CYC-1 -> RUN with no transmission.
REQ-010 WAIT_SYNC: if a SYNC byte arrives in the same cycle as boot-wait expiry, SYNC SHALL win.
REQ-011 LEN_H then LEN_L SHALL capture a 16-bit length LEN, MSB first.
REQ-012 On LEN_L, LEN == 0 or LEN > 2^ADDR_W -> RESP with 0x15 (NAK); otherwise -> DATA.
REQ-013 DATA: each rx_valid SHALL write rx_byte to address counter A.
- mem_wr high for exactly one cycle, the cycle after rx_valid.
- mem_addr = A, mem_din = byte on that cycle.
- Then A increments and the byte is added to the 8-bit modulo-256 checksum.
REQ-014 DATA: after the LEN-th byte -> CSUM.
REQ-015 CSUM: received byte equal to the accumulated sum -> RESP with 0x06 (ACK); otherwise -> RESP with 0x15 (NAK).
REQ-016 CSUM: RAM contents already written SHALL be left unchanged on NAK.
REQ-017 LEN_H to CSUM: the timeout counter clears on every rx_valid.
REQ-018 LEN_H to CSUM: timeout counter reaching BYTE_TO_CYC-1 -> WAIT_SYNC silently.
REQ-019 LEN_H to CSUM: if rx_valid and timeout expiry occur in the same cycle, rx_valid SHALL win.
REQ-020 RESP: SHALL wait until tx_busy == 0, then pulse tx_start for one cycle with tx_byte = the response byte.
REQ-021 RESP: after ACK -> RUN; after NAK -> WAIT_SYNC.
REQ-022 RESP: rx_valid SHALL be ignored.
REQ-023 tx_byte SHALL hold its value until the next tx_start.
REQ-024 RUN: terminal until reset; rx_valid SHALL be ignored.
REQ-025 RUN: cpu_reset SHALL be 0, registered, deasserting the cycle after RUN is entered.
REQ-026 In every state except RUN, cpu_reset SHALL be 1.
REQ-027 RUN: mem_addr, mem_din, mem_rd and mem_wr SHALL be combinational pass-throughs of cpu_addr, cpu_dout, cpu_mem_rd and cpu_mem_wr.
REQ-028 Outside RUN, the loader SHALL drive the RAM; cpu_mem_wr and cpu_mem_rd are ignored; mem_rd = 0.
REQ-029 Only the loader's mem_wr pulses SHALL reach the RAM outside RUN.

Reset
REQ-030 On reset assertion, any time including mid-frame, SHALL enter WAIT_SYNC and clear all counters, LEN and the checksum.
REQ-031 Reset values: cpu_reset=1, tx_start=0, tx_byte=0x00, mem_wr=0, mem_rd=0, mem_addr=0, mem_din=0x00.
REQ-032 A reset mid-frame SHALL abort the load with no response byte.

Verification (bench: ADDR_W=8, BOOT_WAIT_CYC=1000, BYTE_TO_CYC=200)
REQ-033 Valid load:
- Stimulus: A5 00 03 11 22 33 66.
- Response: writes 0x11@0, 0x22@1, 0x33@2; one tx_start with tx_byte=0x06; cpu_reset falls.
REQ-034 Bad checksum:
- Stimulus: A5 00 01 42 43.
- Response: tx_byte=0x15, cpu_reset stays 1; a following valid frame then loads and sends ACK.
REQ-035 Boot timeout:
- Stimulus: no rx_valid for 1000 cycles after reset.
- Response: cpu_reset=0, zero tx_start pulses, zero mem_wr pulses.
REQ-036 Length errors:
- Stimulus: A5 01 01.
- Response: NAK right after LEN_L; same for A5 00 00.
REQ-037 Inter-byte timeout:
- Stimulus: A5 00 02 11, then 200 idle cycles.
- Response: back to WAIT_SYNC with no tx_start; a following valid frame completes normally.
REQ-038 RUN pass-through:
- Stimulus: cpu_mem_wr=1, cpu_addr=0x10, cpu_dout=0x5A, then rx byte A5.
- Response: mem_wr=1, mem_addr=0x10, mem_din=0x5A the same cycle; the A5 causes no state change and no tx_start.
